spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder: the far end of the team's SPI master link. It serves an external master and is clocked entirely by the local system clock.
- SCLK, CS_N and MOSI are oversampled through 2-flop synchronizers, and SCLK edges are detected in the local clock domain.
- Full-duplex: it shifts a DATA_WIDTH word in from MOSI while shifting a pre-loaded word out on MISO.
- Multiple back-to-back words per CS_N assertion are supported.

Parameters:
- DATA_WIDTH, 8: bits per word.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on the leading edge; 1 = sample on the trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB shifted first.

Ports:
- i_chip_clk, in, 1: system clock. Must be at least 8x SCLK.
- i_rst, in, 1: synchronous, active-high reset.
- i_sclk, in, 1: SPI clock, asynchronous.
- i_cs_n, in, 1: chip select, active-low, asynchronous.
- i_mosi, in, 1: master-out data, asynchronous.
- o_miso, out, 1: slave-out data.
- o_miso_oe, out, 1: MISO output enable; high only while selected.
- i_tx_data, in, DATA_WIDTH: next word to transmit.
- i_tx_valid, in, 1: tx word valid.
- o_tx_ready, out, 1: tx buffer empty. Transfer occurs when valid & ready.
- o_rx_data, out, DATA_WIDTH: last complete received word. Held until the next word completes.
- o_rx_valid, out, 1: 1-cycle pulse when o_rx_data updates.
- o_tx_underrun, out, 1: 1-cycle pulse when a word load finds the tx buffer empty.
- o_busy, out, 1: high while CS_N is asserted (synchronized).

Behaviour:
- Clocking and reset:
  - Single clock domain; all flops are on i_chip_clk with synchronous active-high i_rst.
  - Reset values: o_miso 0, o_miso_oe 0, o_rx_data 0, o_rx_valid 0, o_tx_ready 1, o_tx_underrun 0, o_busy 0.
  - Synchronizers reset to idle levels: sclk = CPOL, cs_n = 1, mosi = 0.
- Synchronization and edges:
  - Each async input passes through 2 flops.
  - SCLK and CS_N edges are derived by comparing the synchronized value with its previous value, giving 1-cycle pulses.
  - Leading edge = rise if CPOL=0, fall if CPOL=1.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- Tx buffer:
  - One word deep. o_tx_ready = ~full.
  - On i_tx_valid & o_tx_ready the buffer captures i_tx_data and sets full.
  - At a word load: if full, the buffer moves to the shift register and full clears. If empty, the shift register loads all zeros and o_tx_underrun pulses.
  - If a capture and a load coincide on the same cycle with the buffer empty, the load wins (zeros, underrun), and the new data is held in the buffer for the next word.
- FSM states:
  - IDLE: o_miso_oe 0, o_busy 0.
    - On the synced CS_N falling edge -> LOAD.
  - LOAD (1 cycle): perform a word load; clear the bit counter; set o_miso_oe 1 and o_busy 1.
    - If CPHA=0, drive o_miso with the first tx bit.
    - -> ACTIVE.
  - ACTIVE:
    - Sample edge: shift synced MOSI into rx_shift (per MSB_FIRST) and increment the bit counter.
    - Shift edge: if CPHA=1 and the counter is 0 with no bit yet output for this word, present the first bit; otherwise present the next tx bit.
    - When the counter reaches DATA_WIDTH after a sample:
      - o_rx_data takes the full word and o_rx_valid pulses on the next cycle.
      - The counter clears and a word load occurs in the same cycle, so the next word follows seamlessly.
      - With CPHA=0 the reloaded first bit appears on o_miso at that point.
    - Synced CS_N high -> IDLE.
- Latency: from the pin edge to internal action is 3 i_chip_clk cycles (2 sync + 1 edge register).
- CS_N deassert mid-word:
  - Abort: partial rx is discarded with no o_rx_valid, and the counter clears.
  - The word already loaded to the shift register is lost; the tx buffer contents are retained.
  - o_miso_oe drops the cycle after the rising edge is detected.
- Ignored inputs:
  - SCLK edges while in IDLE are ignored.
  - A CS_N glitch shorter than 2 clocks may be missed; this is acceptable.
- Reset mid-transfer: returns to IDLE with all reset values; the buffer becomes empty.

Decomposition:
- Shared package spi_pkg: mode constants (CPOL/CPHA encodings), default DATA_WIDTH, FSM state typedef (IDLE/LOAD/ACTIVE).
- Sub-module spi_sync_edge: 2-flop synchronizer plus previous-value register, with outputs o_sync, o_rise, o_fall and a sync active-high reset.
  - Instantiated for SCLK and CS_N.
  - MOSI uses the synchronizer only.

Test Plan:
1. Mode 0, MSB first: preload 0xA5; master sends 0x3C with SCLK = clk/8. Expect MISO bits 1,0,1,0,0,1,0,1, then o_rx_data=0x3C with a single o_rx_valid pulse, and o_tx_ready back to 1.
2. Mode 3 (CPOL=1, CPHA=1): preload 0x81; master sends 0xF0. Expect master-captured 0x81 and o_rx_data=0xF0.
3. Back-to-back words in one CS: preload 0x11, and load 0x22 during word 1. Master sends 0xAA, 0x55. Expect two o_rx_valid pulses (0xAA, 0x55), MISO 0x11 then 0x22, and no underrun.
4. Underrun: no preload, CS asserted. Expect o_tx_underrun pulse at LOAD and MISO all zeros for the word; rx still completes.
5. Abort: CS_N released after 5 bits of 0xC3. Expect no o_rx_valid, o_miso_oe low within 4 clocks, and the next transfer of 0x0F receives 0x0F correctly.
6. Reset asserted mid-word (bit 3). Expect all outputs at reset values the next cycle, o_tx_ready=1, and normal operation on a new CS.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM state type for the SPI responder
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  localparam bit CPOL_IDLE_LOW  = 1'b0;
  localparam bit CPOL_IDLE_HIGH = 1'b1;
  localparam bit CPHA_LEADING   = 1'b0;
  localparam bit CPHA_TRAILING  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_if.sv
// rtl/spi_if.sv - SPI pins plus tx/rx word handshake seen by the responder
interface spi_if import spi_pkg::*; #(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
);

  logic                  i_sclk;
  logic                  i_cs_n;
  logic                  i_mosi;
  logic                  o_miso;
  logic                  o_miso_oe;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  o_tx_underrun;
  logic                  o_busy;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
           o_tx_underrun, o_busy
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
           o_tx_underrun, o_busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with registered previous value for edge pulses
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_sync = sync_q;
  assign o_rise = sync_q & ~prev_q;
  assign o_fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled full-duplex SPI responder with a one-word tx buffer
module spi_slave import spi_pkg::*; #(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter bit CPOL       = CPOL_IDLE_LOW,
  parameter bit CPHA       = CPHA_LEADING,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic  i_chip_clk,
  input logic  i_rst,
  spi_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_meta_q, mosi_q;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
    .i_clk  (i_chip_clk),
    .i_rst  (i_rst),
    .i_async(bus.i_sclk),
    .o_sync (sclk_sync),
    .o_rise (sclk_rise),
    .o_fall (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .i_clk  (i_chip_clk),
    .i_rst  (i_rst),
    .i_async(bus.i_cs_n),
    .o_sync (cs_sync),
    .o_rise (cs_rise),
    .o_fall (cs_fall)
  );

  always_ff @(posedge i_chip_clk) begin
    if (i_rst) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      mosi_meta_q <= bus.i_mosi;
      mosi_q      <= mosi_meta_q;
    end
  end

  // Deselect is handled on the level, so the level of SCLK and the CS rise pulse go unused.
  logic unused_sync;
  assign unused_sync = sclk_sync ^ cs_rise;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  spi_state_e            state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q, rx_shift_q, tx_buf_q, rx_data_q;
  logic                  tx_full_q, rx_valid_q, underrun_q;
  logic                  miso_q, miso_oe_q, busy_q;

  logic [DATA_WIDTH-1:0] load_word_d, rx_shift_d;
  logic [CNT_W-1:0]      bit_cnt_d;
  logic                  tx_capture_d, word_done_d, load_now_d;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  assign tx_capture_d = bus.i_tx_valid & ~tx_full_q;
  assign load_word_d  = tx_full_q ? tx_buf_q : '0;
  assign rx_shift_d   = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_q}
                                  : {mosi_q, rx_shift_q[DATA_WIDTH-1:1]};
  assign bit_cnt_d    = bit_cnt_q + CNT_W'(1);
  assign word_done_d  = (bit_cnt_d == CNT_W'(DATA_WIDTH));
  assign load_now_d   = (state_q == ST_LOAD) ||
                        ((state_q == ST_ACTIVE) && !cs_sync && sample_edge && word_done_d);

  always_ff @(posedge i_chip_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      tx_full_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          bit_cnt_q  <= '0;
          rx_shift_q <= '0;
          miso_oe_q  <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (cs_sync) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (sample_edge) begin
            rx_shift_q <= rx_shift_d;
            if (word_done_d) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          // With CPHA=0 the word-boundary reload already presented bit 0, so skip that shift edge.
          end else if (shift_edge && (CPHA || (bit_cnt_q != '0))) begin
            miso_q     <= first_bit(tx_shift_q);
            tx_shift_q <= shift_out(tx_shift_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (load_now_d) begin
        if (tx_full_q) tx_full_q  <= 1'b0;
        else           underrun_q <= 1'b1;
        if (CPHA) begin
          tx_shift_q <= load_word_d;
        end else begin
          tx_shift_q <= shift_out(load_word_d);
          miso_q     <= first_bit(load_word_d);
        end
      end

      // Capture only happens while empty, so it never fights the full-clear above.
      if (tx_capture_d) begin
        tx_buf_q  <= bus.i_tx_data;
        tx_full_q <= 1'b1;
      end
    end
  end

  assign bus.o_miso        = miso_q;
  assign bus.o_miso_oe     = miso_oe_q;
  assign bus.o_tx_ready    = ~tx_full_q;
  assign bus.o_rx_data     = rx_data_q;
  assign bus.o_rx_valid    = rx_valid_q;
  assign bus.o_tx_underrun = underrun_q;
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - bench for spi_slave in mode 0 and mode 3 against a word-level model
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_if #(.DATA_WIDTH(8)) bus0 ();
  spi_if #(.DATA_WIDTH(8)) bus3 ();

  spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_mode0 (
    .i_chip_clk(clk),
    .i_rst     (rst),
    .bus       (bus0)
  );

  spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_mode3 (
    .i_chip_clk(clk),
    .i_rst     (rst),
    .bus       (bus3)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rxq0[$];
  logic [7:0] rxq3[$];
  int         und_cnt[2] = '{0, 0};

  // Word-level model: one-deep buffer, the word currently being shifted, underruns seen.
  bit         mfull[2] = '{1'b0, 1'b0};
  logic [7:0] mbuf[2]  = '{8'h00, 8'h00};
  logic [7:0] mcur[2]  = '{8'h00, 8'h00};
  int         mund[2]  = '{0, 0};

  always @(posedge clk) begin
    #2;
    if (bus0.o_rx_valid === 1'b1) rxq0.push_back(bus0.o_rx_data);
    if (bus3.o_rx_valid === 1'b1) rxq3.push_back(bus3.o_rx_data);
    if (bus0.o_tx_underrun === 1'b1) und_cnt[0]++;
    if (bus3.o_tx_underrun === 1'b1) und_cnt[1]++;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sclk(input bit m3, input logic v);
    if (m3) bus3.i_sclk = v; else bus0.i_sclk = v;
  endtask
  task automatic set_cs(input bit m3, input logic v);
    if (m3) bus3.i_cs_n = v; else bus0.i_cs_n = v;
  endtask
  task automatic set_mosi(input bit m3, input logic v);
    if (m3) bus3.i_mosi = v; else bus0.i_mosi = v;
  endtask

  function automatic logic get_miso(input bit m3);
    return m3 ? bus3.o_miso : bus0.o_miso;
  endfunction
  function automatic logic get_oe(input bit m3);
    return m3 ? bus3.o_miso_oe : bus0.o_miso_oe;
  endfunction
  function automatic logic get_busy(input bit m3);
    return m3 ? bus3.o_busy : bus0.o_busy;
  endfunction
  function automatic logic get_ready(input bit m3);
    return m3 ? bus3.o_tx_ready : bus0.o_tx_ready;
  endfunction

  task automatic model_load(input bit m3);
    if (mfull[m3]) begin
      mcur[m3]  = mbuf[m3];
      mfull[m3] = 1'b0;
    end else begin
      mcur[m3] = 8'h00;
      mund[m3]++;
    end
  endtask

  task automatic check_reset_vals(input bit m3);
    check("rst_miso", get_miso(m3), 0);
    check("rst_miso_oe", get_oe(m3), 0);
    check("rst_rx_data", m3 ? bus3.o_rx_data : bus0.o_rx_data, 0);
    check("rst_rx_valid", m3 ? bus3.o_rx_valid : bus0.o_rx_valid, 0);
    check("rst_tx_ready", get_ready(m3), 1);
    check("rst_underrun", m3 ? bus3.o_tx_underrun : bus0.o_tx_underrun, 0);
    check("rst_busy", get_busy(m3), 0);
  endtask

  task automatic preload(input bit m3, input logic [7:0] d);
    int n = 0;
    while (get_ready(m3) !== 1'b1 && n < 50) begin
      clks(1);
      n++;
    end
    check("tx_ready_before_push", get_ready(m3), 1);
    if (m3) begin bus3.i_tx_data = d; bus3.i_tx_valid = 1'b1; end
    else    begin bus0.i_tx_data = d; bus0.i_tx_valid = 1'b1; end
    clks(1);
    if (m3) bus3.i_tx_valid = 1'b0; else bus0.i_tx_valid = 1'b0;
    mbuf[m3]  = d;
    mfull[m3] = 1'b1;
    check("tx_ready_after_push", get_ready(m3), 0);
  endtask

  task automatic cs_begin(input bit m3);
    set_cs(m3, 1'b0);
    clks(6);
    model_load(m3);
    check("busy_after_select", get_busy(m3), 1);
    check("oe_after_select", get_oe(m3), 1);
    check("tx_ready_after_first_load", get_ready(m3), {31'd0, ~mfull[m3]});
    check("underrun_after_first_load", und_cnt[m3], mund[m3]);
  endtask

  task automatic cs_end(input bit m3);
    clks(4);
    set_cs(m3, 1'b1);
    set_mosi(m3, 1'b0);
    clks(6);
    check("busy_after_deselect", get_busy(m3), 0);
    check("oe_after_deselect", get_oe(m3), 0);
    check("underrun_count", und_cnt[m3], mund[m3]);
  endtask

  // Master side of the link: drives nbits of w MSB first and captures MISO at its sample edge.
  task automatic xfer_bits(input bit m3, input logic [7:0] w, input int nbits,
                           output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!m3) begin
        set_mosi(1'b0, w[i]);
        clks(4);
        set_sclk(1'b0, 1'b1);
        got[i] = get_miso(1'b0);
        clks(4);
        set_sclk(1'b0, 1'b0);
      end else begin
        set_sclk(1'b1, 1'b0);
        set_mosi(1'b1, w[i]);
        clks(4);
        set_sclk(1'b1, 1'b1);
        got[i] = get_miso(1'b1);
        clks(4);
      end
    end
  endtask

  task automatic xfer_word(input bit m3, input logic [7:0] w);
    logic [7:0] got;
    logic [7:0] exp_miso;
    logic [7:0] rxv;
    int         nrx;
    exp_miso = mcur[m3];
    rxv = 8'hxx;
    xfer_bits(m3, w, 8, got);
    model_load(m3);
    check("miso_word", got, exp_miso);
    if (m3) begin
      nrx = rxq3.size();
      if (nrx > 0) rxv = rxq3.pop_front();
    end else begin
      nrx = rxq0.size();
      if (nrx > 0) rxv = rxq0.pop_front();
    end
    check("rx_valid_pulses", nrx, 1);
    check("rx_data", rxv, w);
  endtask

  initial begin
    logic [7:0] got;
    rst = 1'b1;
    bus0.i_sclk = 1'b0; bus0.i_cs_n = 1'b1; bus0.i_mosi = 1'b0;
    bus0.i_tx_data = 8'h00; bus0.i_tx_valid = 1'b0;
    bus3.i_sclk = 1'b1; bus3.i_cs_n = 1'b1; bus3.i_mosi = 1'b0;
    bus3.i_tx_data = 8'h00; bus3.i_tx_valid = 1'b0;
    clks(3);
    check_reset_vals(1'b0);
    check_reset_vals(1'b1);
    rst = 1'b0;
    clks(2);

    // Mode 0 single word.
    preload(1'b0, 8'hA5);
    cs_begin(1'b0);
    xfer_word(1'b0, 8'h3C);
    cs_end(1'b0);
    check("t1_tx_ready", get_ready(1'b0), 1);

    // Mode 3 single word.
    preload(1'b1, 8'h81);
    cs_begin(1'b1);
    xfer_word(1'b1, 8'hF0);
    cs_end(1'b1);

    // Back-to-back words in one select.
    preload(1'b0, 8'h11);
    cs_begin(1'b0);
    preload(1'b0, 8'h22);
    xfer_word(1'b0, 8'hAA);
    xfer_word(1'b0, 8'h55);
    cs_end(1'b0);

    // Underrun with empty buffer.
    cs_begin(1'b0);
    xfer_word(1'b0, 8'($urandom));
    cs_end(1'b0);

    // Abort after 5 bits.
    cs_begin(1'b0);
    xfer_bits(1'b0, 8'hC3, 5, got);
    set_cs(1'b0, 1'b1);
    clks(4);
    check("abort_oe_low", get_oe(1'b0), 0);
    check("abort_no_rx", rxq0.size(), 0);
    clks(4);
    check("abort_underrun_count", und_cnt[0], mund[0]);
    cs_begin(1'b0);
    xfer_word(1'b0, 8'h0F);
    cs_end(1'b0);

    // Randomized transfers on either mode.
    for (int t = 0; t < 8; t++) begin
      bit m;
      int nw;
      m  = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      if (!mfull[m] && $urandom_range(0, 1) == 1) preload(m, 8'($urandom));
      cs_begin(m);
      for (int k = 0; k < nw; k++) begin
        if (!mfull[m] && $urandom_range(0, 1) == 1) preload(m, 8'($urandom));
        xfer_word(m, 8'($urandom));
      end
      cs_end(m);
    end

    // Reset in the middle of a word.
    preload(1'b0, 8'h96);
    cs_begin(1'b0);
    xfer_bits(1'b0, 8'h5A, 3, got);
    rst = 1'b1;
    set_cs(1'b0, 1'b1);
    set_sclk(1'b0, 1'b0);
    set_mosi(1'b0, 1'b0);
    clks(1);
    check_reset_vals(1'b0);
    check_reset_vals(1'b1);
    rst = 1'b0;
    mfull[0] = 1'b0;
    mfull[1] = 1'b0;
    clks(2);
    check("reset_no_rx", rxq0.size(), 0);
    preload(1'b0, 8'h6B);
    cs_begin(1'b0);
    xfer_word(1'b0, 8'hE7);
    cs_end(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
